// File: rtl/calc_time_pkg.sv
// Shared constants and FSM state type for the trapezoidal-profile timing calculators.
package calc_time_pkg;

    // Word positions inside one axis' parameter set.
    localparam int unsigned P_N     = 0;
    localparam int unsigned P_NN    = 1;
    localparam int unsigned P_T0    = 2;
    localparam int unsigned P_TNA   = 3;
    localparam int unsigned P_DELTA = 4;

    // Word positions inside one axis' timing result.
    localparam int unsigned T_ACC    = 0;
    localparam int unsigned T_CRUISE = 1;
    localparam int unsigned T_DEC    = 2;
    localparam int unsigned T_TOTAL  = 3;

    typedef enum logic [2:0] {IDLE, A, M0, M1, M2, M3, SUM, DONE} state_e;

endpackage

// File: rtl/calc_time_multi_if.sv
// Parameter/result bundle between the command decoder and the timing calculator.
interface calc_time_multi_if #(
    parameter int unsigned AXES = 4,
    parameter int unsigned W    = 32,
    parameter int unsigned TW   = 64
);
    localparam int unsigned AW = (AXES > 1) ? $clog2(AXES) : 1;

    logic                               start;
    logic [0:AXES-1][0:4][W-1:0]        params;
    logic [0:AXES-1][0:3][TW-1:0]       timing;
    logic [TW-1:0]                      t_max;
    logic [AW-1:0]                      max_axis;
    logic [AXES-1:0]                    err;
    logic                               busy;
    logic                               finish;

    modport master (
        output start, params,
        input  timing, t_max, max_axis, err, busy, finish
    );

    modport slave (
        input  start, params,
        output timing, t_max, max_axis, err, busy, finish
    );

endinterface

// File: rtl/seq_mul.sv
// Unsigned TW x TW -> TW multiplier with STAGES output registers and a valid pipe.
module seq_mul #(
    parameter int unsigned TW     = 64,
    parameter int unsigned STAGES = 2
) (
    input  logic          clk,
    input  logic          clear,
    input  logic [TW-1:0] a,
    input  logic [TW-1:0] b,
    input  logic          in_valid,
    output logic [TW-1:0] p,
    output logic          out_valid
);

    logic [TW-1:0] prod;
    assign prod = a * b;

    if (STAGES == 0) begin : g_comb
        assign p         = prod;
        assign out_valid = in_valid;
    end else begin : g_pipe
        logic [TW-1:0]     data_q [STAGES];
        logic [STAGES-1:0] vld_q;

        // Data shift; only qualified by vld_q, so it needs no reset.
        always_ff @(posedge clk) begin
            data_q[0] <= prod;
            for (int s = 1; s < STAGES; s++) begin
                data_q[s] <= data_q[s-1];
            end
        end

        // Valid shift, flushed so an aborted product never reaches a new run.
        always_ff @(posedge clk) begin
            if (clear) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= in_valid;
                for (int s = 1; s < STAGES; s++) begin
                    vld_q[s] <= vld_q[s-1];
                end
            end
        end

        assign p         = data_q[STAGES-1];
        assign out_valid = vld_q[STAGES-1];
    end

endmodule

// File: rtl/calc_time_multi.sv
// Multi-axis trapezoidal move timing: per-axis t1/t2/t3/tt through one shared multiplier,
// plus the slowest error-free axis for synchronised arrival.
module calc_time_multi
    import calc_time_pkg::*;
#(
    parameter int unsigned AXES       = 4,
    parameter int unsigned W          = 32,
    parameter int unsigned TW         = 64,
    parameter int unsigned MUL_STAGES = 2
) (
    input logic              clk,
    input logic              reset,
    calc_time_multi_if.slave bus
);

    localparam int unsigned AW   = (AXES > 1) ? $clog2(AXES) : 1;
    localparam logic [AW-1:0] LAST = AW'(AXES - 1);

    state_e                      state;
    logic [0:AXES-1][0:4][W-1:0] prm;
    logic [AW-1:0]               idx;
    logic                        issued;
    logic                        long_q;
    logic [TW-1:0]               a_q, p0, p1, p2, p3;

    // Current axis operands, zero-extended to the arithmetic width.
    logic [W-1:0]  n_w, nn_w;
    logic [W:0]    nn2, span;
    logic          long_c;
    logic [TW-1:0] t0_x, tna_x, dl_x, span_x;

    assign n_w    = prm[idx][P_N];
    assign nn_w   = prm[idx][P_NN];
    assign t0_x   = TW'(prm[idx][P_T0]);
    assign tna_x  = TW'(prm[idx][P_TNA]);
    assign dl_x   = TW'(prm[idx][P_DELTA]);
    assign nn2    = {nn_w, 1'b0};
    assign long_c = {1'b0, n_w} > nn2;
    assign span   = {1'b0, n_w} - nn2;
    assign span_x = TW'(span);

    logic [TW-1:0] mul_x, mul_y, mul_p;
    logic          mul_vin, mul_vout;

    // Operand select for the shared multiplier; issue once on entry to each M state.
    always_comb begin
        mul_x   = '0;
        mul_y   = '0;
        mul_vin = 1'b0;
        case (state)
            M0: begin
                mul_x = t0_x;
                mul_y = a_q;
                mul_vin = !issued;
            end
            M1: begin
                mul_x = dl_x;
                mul_y = (a_q == '0) ? '0 : a_q - TW'(1);
                mul_vin = !issued;
            end
            M2: begin
                mul_x = a_q;
                mul_y = p1;
                mul_vin = !issued;
            end
            M3: begin
                mul_x = long_q ? tna_x : dl_x;
                mul_y = long_q ? span_x : a_q;
                mul_vin = !issued;
            end
            default: ;
        endcase
    end

    seq_mul #(
        .TW     (TW),
        .STAGES (MUL_STAGES)
    ) u_mul (
        .clk       (clk),
        .clear     (reset || !bus.start),
        .a         (mul_x),
        .b         (mul_y),
        .in_valid  (mul_vin),
        .p         (mul_p),
        .out_valid (mul_vout)
    );

    // Results for the axis in SUM; short odd moves cruise for one middle step.
    logic [TW-1:0] t1, t2, tt;
    logic          err_c;

    assign t1    = p0 - (p2 >> 1);
    assign t2    = long_q ? p3 : (n_w[0] ? t0_x - p3 : '0);
    assign tt    = t1 + t2 + t1;
    assign err_c = (p1 > t0_x) || (!long_q && n_w[0] && (p3 > t0_x));

    // Sequencer: walks every axis through A, M0..M3, SUM, then holds results in DONE.
    always_ff @(posedge clk) begin
        if (reset || !bus.start) begin
            state        <= IDLE;
            idx          <= '0;
            issued       <= 1'b0;
            long_q       <= 1'b0;
            a_q          <= '0;
            p0           <= '0;
            p1           <= '0;
            p2           <= '0;
            p3           <= '0;
            bus.timing   <= '0;
            bus.t_max    <= '0;
            bus.max_axis <= '0;
            bus.err      <= '0;
            bus.busy     <= 1'b0;
            bus.finish   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    prm      <= bus.params;
                    idx      <= '0;
                    bus.busy <= 1'b1;
                    state    <= A;
                end
                A: begin
                    a_q    <= long_c ? TW'(nn_w) : TW'(n_w >> 1);
                    long_q <= long_c;
                    issued <= 1'b0;
                    state  <= M0;
                end
                M0: begin
                    if (mul_vout) begin
                        p0 <= mul_p; issued <= 1'b0; state <= M1;
                    end else issued <= 1'b1;
                end
                M1: begin
                    if (mul_vout) begin
                        p1 <= mul_p; issued <= 1'b0; state <= M2;
                    end else issued <= 1'b1;
                end
                M2: begin
                    if (mul_vout) begin
                        p2 <= mul_p; issued <= 1'b0; state <= M3;
                    end else issued <= 1'b1;
                end
                M3: begin
                    if (mul_vout) begin
                        p3 <= mul_p; issued <= 1'b0; state <= SUM;
                    end else issued <= 1'b1;
                end
                SUM: begin
                    if (err_c) begin
                        bus.timing[idx] <= '0;
                    end else begin
                        bus.timing[idx][T_ACC]    <= t1;
                        bus.timing[idx][T_CRUISE] <= t2;
                        bus.timing[idx][T_DEC]    <= t1;
                        bus.timing[idx][T_TOTAL]  <= tt;
                    end
                    bus.err[idx] <= err_c;
                    // Strict compare keeps the lower index on a tie.
                    if (!err_c && (tt > bus.t_max)) begin
                        bus.t_max    <= tt;
                        bus.max_axis <= idx;
                    end
                    if (idx == LAST) begin
                        bus.busy   <= 1'b0;
                        bus.finish <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx   <= idx + AW'(1);
                        state <= A;
                    end
                end
                DONE: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_time_multi.sv
// Randomised and directed check of calc_time_multi against a step-sum reference model.
module tb_calc_time_multi;
    import calc_time_pkg::*;

    localparam int unsigned AXES = 4;
    localparam int unsigned W    = 32;
    localparam int unsigned TW   = 64;
    localparam int unsigned MS   = 2;
    localparam int unsigned P    = 2 + 4 * (MS + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    calc_time_multi_if #(.AXES(AXES), .W(W), .TW(TW)) bus ();

    calc_time_multi #(
        .AXES       (AXES),
        .W          (W),
        .TW         (TW),
        .MUL_STAGES (MS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0]     prm     [AXES][5];
    logic [63:0]     exp_tim [AXES][4];
    logic [AXES-1:0] exp_err;
    logic [63:0]     exp_tmax;
    int unsigned     exp_max;
    logic            chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: acceleration time is the sum of the falling step delays t0, t0-d, ...
    function automatic void model_axis(input logic [31:0] n, nn, t0, tna, dl,
                                       output logic [63:0] t1, t2, tt, output logic e);
        longint unsigned nl, nnl, t0l, tnal, dll, a;
        logic lng;
        nl = n; nnl = nn; t0l = t0; tnal = tna; dll = dl;
        lng = nl > 2 * nnl;
        a = lng ? nnl : nl / 2;
        e = 1'b0;
        if (a > 0 && dll * (a - 1) > t0l) e = 1'b1;            // last accel delay negative
        if (!lng && (nl % 2 == 1) && dll * a > t0l) e = 1'b1;  // middle step delay negative
        t1 = 0;
        for (longint unsigned j = 0; j < a; j++) t1 += t0l - j * dll;
        t2 = lng ? tnal * (nl - 2 * nnl) : ((nl % 2 == 1) ? t0l - dll * a : 0);
        tt = t1 + t2 + t1;
        if (e) begin
            t1 = 0; t2 = 0; tt = 0;
        end
    endfunction

    task automatic compute_expected();
        logic [63:0] t1, t2, tt;
        logic e;
        exp_tmax = 0;
        exp_max  = 0;
        for (int i = 0; i < AXES; i++) begin
            model_axis(prm[i][P_N], prm[i][P_NN], prm[i][P_T0], prm[i][P_TNA],
                       prm[i][P_DELTA], t1, t2, tt, e);
            exp_tim[i][T_ACC]    = t1;
            exp_tim[i][T_CRUISE] = t2;
            exp_tim[i][T_DEC]    = t1;
            exp_tim[i][T_TOTAL]  = tt;
            exp_err[i] = e;
            if (!e && tt > exp_tmax) begin
                exp_tmax = tt;
                exp_max  = i;
            end
        end
    endtask

    // Compare process: full result set against the model while results are valid.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < AXES; i++)
                for (int j = 0; j < 4; j++)
                    chk($sformatf("timing[%0d][%0d]", i, j), bus.timing[i][j], exp_tim[i][j]);
            chk("err", 64'(bus.err), 64'(exp_err));
            chk("t_max", bus.t_max, exp_tmax);
            chk("max_axis", 64'(bus.max_axis), 64'(exp_max));
            chk("finish_hold", 64'(bus.finish), 64'd1);
        end
    end

    task automatic check_zero(input string tag);
        logic [63:0] acc;
        acc = 0;
        for (int i = 0; i < AXES; i++)
            for (int j = 0; j < 4; j++) acc |= bus.timing[i][j];
        chk({tag, "/timing_zero"}, acc, 64'd0);
        chk({tag, "/t_max_zero"}, bus.t_max, 64'd0);
        chk({tag, "/flags_zero"}, 64'({bus.err, bus.max_axis, bus.busy, bus.finish}), 64'd0);
    endtask

    task automatic drive_params();
        for (int i = 0; i < AXES; i++)
            for (int j = 0; j < 5; j++) bus.params[i][j] = prm[i][j];
    endtask

    // Starts a run (or releases reset with start held) and waits into DONE.
    task automatic run_go(input string tag, input bit release_reset);
        int n;
        compute_expected();
        drive_params();
        bus.start = 1'b1;
        if (release_reset) reset = 1'b0;
        @(posedge clk); #1;
        chk({tag, "/busy_start"}, 64'(bus.busy), 64'd1);
        // Mid-run parameter changes must be ignored.
        for (int i = 0; i < AXES; i++)
            for (int j = 0; j < 5; j++) bus.params[i][j] = $urandom;
        n = 0;
        while (!bus.finish && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "/finish_latency"}, 64'(n), 64'(AXES * P));
        chk({tag, "/busy_done"}, 64'(bus.busy), 64'd0);
        chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b0;
    endtask

    task automatic run_stop(input string tag);
        bus.start = 1'b0;
        @(posedge clk); #1;
        check_zero({tag, "/stop"});
    endtask

    task automatic set_axis(input int i, input logic [31:0] n, nn, t0, tna, dl);
        prm[i][P_N] = n; prm[i][P_NN] = nn; prm[i][P_T0] = t0;
        prm[i][P_TNA] = tna; prm[i][P_DELTA] = dl;
    endtask

    task automatic randomise_all();
        for (int i = 0; i < AXES; i++)
            set_axis(i, $urandom_range(3000, 0), $urandom_range(1500, 0),
                     $urandom_range(200000, 0), $urandom_range(5000, 0), $urandom_range(200, 0));
    endtask

    initial begin
        logic [63:0] t1, t2, tt;
        logic e;

        // Pin the model on hand-computed cases.
        model_axis(1000, 100, 5000, 1000, 40, t1, t2, tt, e);
        chk("model_long_t1", t1, 64'd302000);
        chk("model_long_t2", t2, 64'd800000);
        chk("model_long_tt", tt, 64'd1404000);
        chk("model_long_err", 64'(e), 64'd0);
        model_axis(51, 100, 5000, 0, 40, t1, t2, tt, e);
        chk("model_short_t1", t1, 64'd113000);
        chk("model_short_t2", t2, 64'd4000);
        chk("model_short_tt", tt, 64'd230000);
        model_axis(1000, 100, 100, 1000, 40, t1, t2, tt, e);
        chk("model_underflow_err", 64'(e), 64'd1);

        reset = 1'b1;
        bus.start = 1'b0;
        for (int i = 0; i < AXES; i++)
            for (int j = 0; j < 5; j++) bus.params[i][j] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;

        // Long, underflow, short odd, and an odd-middle underflow whose raw tt is huge.
        set_axis(0, 1000, 100, 5000, 1000, 40);
        set_axis(1, 1000, 100, 100, 1000, 40);
        set_axis(2, 51, 100, 5000, 0, 40);
        set_axis(3, 2001, 1500, 99950, 0, 100);
        run_go("mixed", 1'b0);
        chk("mixed/t1_0", bus.timing[0][T_ACC], 64'd302000);
        chk("mixed/t2_0", bus.timing[0][T_CRUISE], 64'd800000);
        chk("mixed/t3_0", bus.timing[0][T_DEC], 64'd302000);
        chk("mixed/tt_0", bus.timing[0][T_TOTAL], 64'd1404000);
        chk("mixed/tt_1", bus.timing[1][T_TOTAL], 64'd0);
        chk("mixed/t1_2", bus.timing[2][T_ACC], 64'd113000);
        chk("mixed/t2_2", bus.timing[2][T_CRUISE], 64'd4000);
        chk("mixed/tt_2", bus.timing[2][T_TOTAL], 64'd230000);
        chk("mixed/err", 64'(bus.err), 64'b1010);
        chk("mixed/t_max", bus.t_max, 64'd1404000);
        chk("mixed/max_axis", 64'(bus.max_axis), 64'd0);
        run_stop("mixed");

        // Axis 2 is the long move, the rest are short.
        for (int i = 0; i < AXES; i++) set_axis(i, 51, 100, 5000, 0, 40);
        set_axis(2, 1000, 100, 5000, 1000, 40);
        run_go("four", 1'b0);
        chk("four/t_max", bus.t_max, 64'd1404000);
        chk("four/max_axis", 64'(bus.max_axis), 64'd2);
        run_stop("four");

        // Abort: start sampled low at edge k+20.
        randomise_all();
        drive_params();
        bus.start = 1'b1;
        @(posedge clk); #1;
        repeat (19) @(posedge clk);
        #1;
        chk("abort/busy_before", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        @(posedge clk); #1;
        check_zero("abort");

        // Zero-length moves.
        randomise_all();
        for (int i = 0; i < AXES; i++) prm[i][P_N] = 0;
        run_go("zero", 1'b0);
        chk("zero/err", 64'(bus.err), 64'd0);
        chk("zero/tt_3", bus.timing[3][T_TOTAL], 64'd0);
        run_stop("zero");

        // Reset at edge k+30, start held; the tie run begins as reset releases.
        randomise_all();
        drive_params();
        bus.start = 1'b1;
        @(posedge clk); #1;
        repeat (29) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_zero("reset_mid");
        set_axis(0, 1000, 100, 100, 1000, 40);
        set_axis(1, 51, 100, 5000, 0, 40);
        set_axis(2, 1000, 100, 100, 1000, 40);
        set_axis(3, 51, 100, 5000, 0, 40);
        run_go("tie", 1'b1);
        chk("tie/max_axis", 64'(bus.max_axis), 64'd1);
        chk("tie/t_max", bus.t_max, 64'd230000);
        run_stop("tie");

        for (int r = 0; r < 15; r++) begin
            randomise_all();
            run_go($sformatf("rand%0d", r), 1'b0);
            run_stop($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
